ct_f_spsram_256x52_ctrl: RTL

Access controller sitting directly upstream of the 256x52 single-port SRAM macro; it owns the macro's CEN/GWEN/WEN/A/D pins and consumes its Q. After reset, or on request, it clears all 256 entries to INIT_DATA. It then serialises a valid/ready read/write request stream onto the single port, with per-half write enables, and returns read data in order through a credit-controlled response buffer with backpressure.

---
 rtl/ct_f_spsram_256x52_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ct_f_spsram_256x52_ctrl.sv
// Access controller for the 256x52 single-port SRAM macro: array clear, in-order
// request serialisation with half-word write enables, credit-controlled read responses.
module ct_f_spsram_256x52_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 52,
    parameter int                    RSP_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_wbe,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam int LO_W  = DATA_WIDTH / 2;
    localparam int HI_W  = DATA_WIDTH - LO_W;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      rsp_count_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
    logic                  rd_issue_q, rd_ret_q;

    logic                  cen_d, gwen_d;
    logic [DATA_WIDTH-1:0] wen_d, d_d;
    logic [ADDR_WIDTH-1:0] a_d;
    logic                  credit_avail, accept, accept_rd, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Outstanding reads plus buffered responses may never exceed the buffer size.
    assign credit_avail = ({1'b0, inflight_q} + {1'b0, rsp_count_q}) < CREDITS;
    assign req_rdy      = (state_q == ST_RUN) && credit_avail;
    assign init_done    = (state_q == ST_RUN);
    assign accept       = req_vld && req_rdy;
    assign accept_rd    = accept && !req_wr;
    assign push         = rd_ret_q;
    assign rsp_vld      = (rsp_count_q != '0);
    assign pop          = rsp_vld && rsp_rdy;
    assign rsp_rdata    = rsp_vld ? rsp_mem[rd_ptr_q] : '0;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cen_d   = 1'b1;
        gwen_d  = 1'b1;
        wen_d   = '1;
        a_d     = sram_a;
        d_d     = sram_d;
        unique case (state_q)
            ST_INIT: begin
                cen_d  = 1'b0;
                gwen_d = 1'b0;
                wen_d  = '0;
                a_d    = cnt_q;
                d_d    = INIT_DATA;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    cen_d = 1'b0;
                    a_d   = req_addr;
                    if (req_wr) begin
                        gwen_d = ~|req_wbe;
                        wen_d  = {{HI_W{~req_wbe[1]}}, {LO_W{~req_wbe[0]}}};
                        d_d    = req_wdata;
                    end
                end
                if (init_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight_q == '0 && rsp_count_q == '0) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept_rd && !push)      inflight_d = inflight_q + 1'b1;
        else if (!accept_rd && push) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Read data from the macro lands two edges after acceptance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sram_cen   <= 1'b1;
            sram_gwen  <= 1'b1;
            sram_wen   <= '1;
            sram_a     <= '0;
            sram_d     <= '0;
            rd_issue_q <= 1'b0;
            rd_ret_q   <= 1'b0;
        end else begin
            sram_cen   <= cen_d;
            sram_gwen  <= gwen_d;
            sram_wen   <= wen_d;
            sram_a     <= a_d;
            sram_d     <= d_d;
            rd_issue_q <= accept_rd;
            rd_ret_q   <= rd_issue_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   rsp_count_q <= rsp_count_q + 1'b1;
                2'b01:   rsp_count_q <= rsp_count_q - 1'b1;
                default: rsp_count_q <= rsp_count_q;
            endcase
        end
    end

    // NOTE: the response storage is not reset; rsp_rdata is masked by rsp_vld, so
    // stale entries never reach the output and the array stays a plain register file.
    always_ff @(posedge CLK) begin
        if (push) rsp_mem[wr_ptr_q] <= sram_q;
    end

    rsp_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        push |-> (rsp_count_q != FULL_CNT));

endmodule
